// File: rtl/rectify_coord_split.sv
// rectify_coord_split: splits fixed-point remap coordinates into an integer
// neighbour address and a truncated fraction for the bilinear interpolator.
// Tracks raster position (sof/eol/eof), flags out-of-image neighbourhoods,
// and sequences each frame through IDLE/RUN/DONE.
// Optional build macro RECTIFY_COORD_CLAMP_EN: out-of-range axes saturate to
// the last valid neighbourhood (int = size-2, fraction all-ones) instead of
// having their fractions zeroed.
module rectify_coord_split #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int INT_W   = 10,
  parameter int FRAC_W  = 8,
  parameter int D_width = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic                      start,
  input  logic                      map_valid,
  input  logic [INT_W+FRAC_W-1:0]   map_x,
  input  logic [INT_W+FRAC_W-1:0]   map_y,
  output logic                      out_valid,
  output logic [INT_W-1:0]          x_int,
  output logic [INT_W-1:0]          y_int,
  output logic [D_width-1:0]        dx,
  output logic [D_width-1:0]        dy,
  output logic                      oob,
  output logic                      sof,
  output logic                      eol,
  output logic                      eof,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      drop_err
);

  localparam int CW     = INT_W + FRAC_W;
  localparam int STAGES = 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [INT_W-1:0] COL_LAST = INT_W'(IMG_W - 1);
  localparam logic [INT_W-1:0] ROW_LAST = INT_W'(IMG_H - 1);
  localparam logic [INT_W-1:0] X_MAX    = INT_W'(IMG_W - 2);
  localparam logic [INT_W-1:0] Y_MAX    = INT_W'(IMG_H - 2);

  logic [1:0]        state;
  logic [INT_W-1:0]  col, row;
  logic              fd_q;
  logic              accept;

  // vld_pipe[0] = stage 1 holds a sample, vld_pipe[STAGES] = outputs valid
  logic [STAGES:0]   vld_pipe;

  logic [INT_W-1:0]   s1_x, s1_y;
  logic [D_width-1:0] s1_dx, s1_dy;
  logic               s1_sof, s1_eol, s1_eof;
  logic               s1_ox, s1_oy;

  // fraction bits below D_width are intentionally discarded (truncation)
  logic [CW-1:0]      unused_map;
  assign unused_map = map_x ^ map_y;

  assign accept     = (state == S_RUN) && map_valid;
  assign busy       = (state == S_RUN);
  assign out_valid  = vld_pipe[STAGES];
  // registered pulse, but never presented while the pipeline is stalled
  assign frame_done = fd_q && clk_en;

  assign s1_ox = (s1_x > X_MAX);
  assign s1_oy = (s1_y > Y_MAX);

  // frame sequencer: raster counters, drop detection, end-of-frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      col      <= '0;
      row      <= '0;
      drop_err <= 1'b0;
      fd_q     <= 1'b0;
    end else if (clk_en) begin
      fd_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (map_valid) drop_err <= 1'b1;
          if (start) begin
            state <= S_RUN;
            col   <= '0;
            row   <= '0;
          end
        end
        S_RUN: begin
          if (map_valid) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) state <= S_DONE;
              else                 row   <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (map_valid) drop_err <= 1'b1;
          // eof is on the outputs this cycle, so the frame has fully drained
          if (vld_pipe[STAGES] && eof) begin
            fd_q  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // stage 1: split the coordinate and tag raster position
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
    end else if (clk_en) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], accept};
      s1_sof   <= accept && (col == '0) && (row == '0);
      s1_eol   <= accept && (col == COL_LAST);
      s1_eof   <= accept && (col == COL_LAST) && (row == ROW_LAST);
      if (accept) begin
        s1_x  <= map_x[CW-1:FRAC_W];
        s1_y  <= map_y[CW-1:FRAC_W];
        s1_dx <= map_x[FRAC_W-1 -: D_width];
        s1_dy <= map_y[FRAC_W-1 -: D_width];
      end
    end
  end

  // stage 2: bounds handling and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      x_int <= '0;
      y_int <= '0;
      dx    <= '0;
      dy    <= '0;
      oob   <= 1'b0;
      sof   <= 1'b0;
      eol   <= 1'b0;
      eof   <= 1'b0;
    end else if (clk_en) begin
      sof <= s1_sof;
      eol <= s1_eol;
      eof <= s1_eof;
      if (vld_pipe[0]) begin
        oob <= s1_ox || s1_oy;
`ifdef RECTIFY_COORD_CLAMP_EN
        x_int <= s1_ox ? X_MAX : s1_x;
        y_int <= s1_oy ? Y_MAX : s1_y;
        dx    <= s1_ox ? {D_width{1'b1}} : s1_dx;
        dy    <= s1_oy ? {D_width{1'b1}} : s1_dy;
`else
        x_int <= s1_x;
        y_int <= s1_y;
        dx    <= (s1_ox || s1_oy) ? '0 : s1_dx;
        dy    <= (s1_ox || s1_oy) ? '0 : s1_dy;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rectify_coord_split.sv
// Bench for rectify_coord_split (IMG_W=4, IMG_H=3): a table-driven frame,
// hand-written corner sequences, then randomized traffic checked against a
// frame-level reference model.
module tb_rectify_coord_split;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int IW = 10;
  localparam int FW = 8;
  localparam int DW = 6;
  localparam int CW = IW + FW;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] x;
    logic [IW-1:0] y;
    logic [DW-1:0] dx;
    logic [DW-1:0] dy;
    logic          oob;
    logic          sof;
    logic          eol;
    logic          eof;
  } out_t;

  typedef struct {
    logic [CW-1:0] mx;
    logic [CW-1:0] my;
    out_t          e;
  } vec_t;

  logic clk = 0, rst = 0, clk_en = 0, start = 0, map_valid = 0;
  logic [CW-1:0] map_x = '0, map_y = '0;
  logic out_valid, oob, sof, eol, eof, busy, frame_done, drop_err;
  logic [IW-1:0] x_int, y_int;
  logic [DW-1:0] dx, dy;

  rectify_coord_split #(.IMG_W(W), .IMG_H(H), .INT_W(IW), .FRAC_W(FW), .D_width(DW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .map_valid(map_valid),
    .map_x(map_x), .map_y(map_y), .out_valid(out_valid), .x_int(x_int), .y_int(y_int),
    .dx(dx), .dy(dy), .oob(oob), .sof(sof), .eol(eol), .eof(eof), .busy(busy),
    .frame_done(frame_done), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit chk_en = 0, tbl_on = 0;
  int tbl_i = 0, fd_cnt = 0;
  vec_t tbl[12];

  // reference model state: 0 idle, 1 running, 2 draining
  int   m_state = 0, m_n = 0;
  bit   m_drop = 0, m_fd = 0;
  out_t p1 = '0, p2 = '0;

  // expected output for the n-th accepted sample of a frame
  function automatic out_t ref_pix(logic [CW-1:0] mx, logic [CW-1:0] my, int n);
    out_t r;
    int xi, yi, fx, fy;
    bit ox, oy;
    xi = int'(mx) / 256;  fx = (int'(mx) % 256) / 4;
    yi = int'(my) / 256;  fy = (int'(my) % 256) / 4;
    ox = xi > W - 2;
    oy = yi > H - 2;
`ifdef RECTIFY_COORD_CLAMP_EN
    if (ox) begin xi = W - 2; fx = 63; end
    if (oy) begin yi = H - 2; fy = 63; end
`else
    if (ox || oy) begin fx = 0; fy = 0; end
`endif
    r.vld = 1'b1;
    r.x = IW'(xi);  r.y = IW'(yi);
    r.dx = DW'(fx); r.dy = DW'(fy);
    r.oob = ox || oy;
    r.sof = (n == 0);
    r.eol = (n % W) == W - 1;
    r.eof = (n == W * H - 1);
    return r;
  endfunction

  task automatic model_step(bit r, bit st, bit mv, bit ce, logic [CW-1:0] mx, logic [CW-1:0] my);
    out_t np1;
    bit   fdn;
    if (r) begin
      m_state = 0; m_n = 0; m_drop = 0; m_fd = 0; p1 = '0; p2 = '0;
      return;
    end
    if (!ce) return;
    fdn = (m_state == 2) && p2.vld && p2.eof;
    np1 = '0;
    case (m_state)
      0: begin
        if (mv) m_drop = 1;
        if (st) begin m_state = 1; m_n = 0; end
      end
      1: if (mv) begin
        np1 = ref_pix(mx, my, m_n);
        m_n++;
        if (m_n == W * H) m_state = 2;
      end
      default: begin
        if (mv) m_drop = 1;
        if (fdn) m_state = 0;
      end
    endcase
    p2 = p1;
    p1 = np1;
    m_fd = fdn;
  endtask

  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
    end
  endtask

  task automatic check_now();
    out_t a;
    a = '{out_valid, x_int, y_int, dx, dy, oob, sof, eol, eof};
    if (frame_done === 1'b1) fd_cnt++;
    if (!chk_en) return;
    cmp("ctrl{vld,busy,fdone,drop}", 64'({out_valid, busy, frame_done, drop_err}),
        64'({p2.vld, m_state == 1, m_fd && clk_en, m_drop}));
    if (p2.vld) cmp("model_data", 64'(a), 64'(p2));
    if (tbl_on && out_valid === 1'b1) begin
      if (tbl_i < 12) cmp($sformatf("table[%0d]", tbl_i), 64'(a), 64'(tbl[tbl_i].e));
      tbl_i++;
    end
  endtask

  // one clock: apply inputs, check outputs for this cycle, advance model
  task automatic tick(bit st, bit mv, bit ce, logic [CW-1:0] mx, logic [CW-1:0] my);
    start = st; map_valid = mv; clk_en = ce; map_x = mx; map_y = my;
    #1;
    check_now();
    @(posedge clk);
    model_step(rst, st, mv, ce, mx, my);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(0, 0, 1, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1;
    tick(0, 0, 1, '0, '0);
    rst = 0;
    start = 0; map_valid = 0; clk_en = 1;
    #1;
    cmp("reset_zero", 64'({out_valid, x_int, y_int, dx, dy, oob, sof, eol, eof, busy, frame_done, drop_err}), 64'(0));
  endtask

  function automatic logic [CW-1:0] rc(int lim);
    if ($urandom_range(0, 9) == 0) return CW'($urandom);
    return {IW'($urandom_range(0, lim)), FW'($urandom)};
  endfunction

  task automatic set_vec(int i, logic [CW-1:0] mx, logic [CW-1:0] my,
                         int x, int y, int fx, int fy, bit o);
    tbl[i].mx = mx; tbl[i].my = my;
    tbl[i].e = '{1'b1, IW'(x), IW'(y), DW'(fx), DW'(fy), o,
                 i == 0, (i % W) == W - 1, i == W * H - 1};
  endtask

  initial begin
    set_vec(0,  18'h00180, 18'h00140, 1, 1, 'h20, 'h10, 0);
    set_vec(2,  18'h000FF, 18'h001FC, 0, 1, 'h3F, 'h3F, 0);
    set_vec(3,  18'h00203, 18'h00000, 2, 0, 0, 0, 0);
    set_vec(6,  18'h00200, 18'h00100, 2, 1, 0, 0, 0);
    set_vec(8,  18'h00004, 18'h00008, 0, 0, 1, 2, 0);
    set_vec(9,  18'h001FF, 18'h00000, 1, 0, 'h3F, 0, 0);
    set_vec(10, 18'h00100, 18'h00100, 1, 1, 0, 0, 0);
    set_vec(11, 18'h00280, 18'h00180, 2, 1, 'h20, 'h20, 0);
`ifdef RECTIFY_COORD_CLAMP_EN
    set_vec(1,  18'h00340, 18'h00080, 2, 0, 'h3F, 'h20, 1);
    set_vec(4,  18'h00180, 18'h00240, 1, 1, 'h20, 'h3F, 1);
    set_vec(5,  18'h3FFFF, 18'h3FFFF, 2, 1, 'h3F, 'h3F, 1);
    set_vec(7,  18'h00300, 18'h00100, 2, 1, 'h3F, 0, 1);
`else
    set_vec(1,  18'h00340, 18'h00080, 3, 0, 0, 0, 1);
    set_vec(4,  18'h00180, 18'h00240, 1, 2, 0, 0, 1);
    set_vec(5,  18'h3FFFF, 18'h3FFFF, 'h3FF, 'h3FF, 0, 0, 1);
    set_vec(7,  18'h00300, 18'h00100, 3, 1, 0, 0, 1);
`endif

    @(negedge clk);
    do_reset();
    chk_en = 1;

    // table frame, back-to-back accepts
    tick(1, 0, 1, '0, '0);
    tbl_on = 1; tbl_i = 0; fd_cnt = 0;
    for (int i = 0; i < 12; i++) tick(0, 1, 1, tbl[i].mx, tbl[i].my);
    idle(6);
    tbl_on = 0;
    cmp("table_beats", 64'(tbl_i), 64'(12));
    cmp("table_frame_done_cnt", 64'(fd_cnt), 64'(1));

    // samples in IDLE are dropped, including the one alongside start
    tick(0, 1, 1, rc(W), rc(H));
    tick(0, 1, 1, rc(W), rc(H));
    tick(1, 1, 1, rc(W), rc(H));
    // toggling valid across a whole frame
    for (int i = 0; i < 24; i++) tick(0, (i % 2) == 0, 1, rc(W - 1), rc(H - 1));
    idle(6);

    // clk_en held low mid-frame with map_valid asserted
    tick(1, 0, 1, '0, '0);
    for (int i = 0; i < 5; i++) tick(0, 1, 1, rc(W), rc(H));
    for (int i = 0; i < 5; i++) tick(0, 1, 0, rc(W), rc(H));
    for (int i = 0; i < 7; i++) tick(0, 1, 1, rc(W), rc(H));
    tick(0, 0, 1, '0, '0);
    tick(0, 0, 0, '0, '0);
    tick(0, 0, 0, '0, '0);
    idle(6);

    // reset after 5 of 12 accepts, then a clean frame
    tick(1, 0, 1, '0, '0);
    for (int i = 0; i < 5; i++) tick(0, 1, 1, rc(W), rc(H));
    do_reset();
    tick(1, 0, 1, '0, '0);
    for (int i = 0; i < 12; i++) tick(0, 1, 1, rc(W), rc(H));
    idle(6);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      tick($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) < 17, rc(W), rc(H));
      rst = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
